// File: rtl/sr_cmd_gen.sv
// Debounced set/clear command generator driving the S/R inputs of the latch stage.
// Each button is synchronized, debounced and edge-detected into a sticky request; a small FSM serves one request at a time.
module sr_cmd_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic set_btn_i,
  input  logic clr_btn_i,
  output logic S_o,
  output logic R_o,
  output logic busy_o,
  output logic conflict_o
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PUL_MAX = PW'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE_S = 2'd1,
    PULSE_R = 2'd2,
    GAP     = 2'd3
  } state_t;

  // Bit 0 is the set channel, bit 1 the clear channel.
  logic [1:0]         btn_s;
  logic [1:0]         sync1_q, sync2_q;
  logic [1:0]         deb_q, deb_d, deb_dly_q;
  logic [1:0][DW-1:0] cnt_q, cnt_d;
  logic [1:0]         pend_q, pend_d;
  logic [1:0]         rise_s, take_s;
  logic               conflict_s;
  state_t             state_q, state_d;
  logic [PW-1:0]      pcnt_q, pcnt_d;

  assign btn_s  = {clr_btn_i, set_btn_i};
  assign rise_s = deb_q & ~deb_dly_q;

  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_MAX) begin
          deb_d[i] = sync2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + DW'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    pcnt_d     = pcnt_q;
    take_s     = 2'b00;
    conflict_s = 1'b0;
    case (state_q)
      IDLE: begin
        // Simultaneous requests are ambiguous, so both are dropped.
        if (pend_q == 2'b11) begin
          take_s     = 2'b11;
          conflict_s = 1'b1;
        end else if (pend_q[0]) begin
          take_s  = 2'b01;
          state_d = PULSE_S;
          pcnt_d  = PUL_MAX;
        end else if (pend_q[1]) begin
          take_s  = 2'b10;
          state_d = PULSE_R;
          pcnt_d  = PUL_MAX;
        end else begin
          state_d = IDLE;
        end
      end
      PULSE_S, PULSE_R: begin
        if (pcnt_q == '0) begin
          state_d = GAP;
        end else begin
          pcnt_d = pcnt_q - PW'(1);
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    pend_d = rise_s | (pend_q & ~take_s);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q   <= 2'b00;
      sync2_q   <= 2'b00;
      deb_q     <= 2'b00;
      deb_dly_q <= 2'b00;
      cnt_q     <= '0;
      pend_q    <= 2'b00;
      state_q   <= IDLE;
      pcnt_q    <= '0;
    end else begin
      sync1_q   <= btn_s;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
    end
  end

  assign S_o        = (state_q == PULSE_S);
  assign R_o        = (state_q == PULSE_R);
  assign busy_o     = (state_q != IDLE);
  assign conflict_o = conflict_s;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Self-checking bench for sr_cmd_gen: directed scenarios plus random bouncing buttons
// against a history-based reference model.
module tb_sr_cmd_gen;

  localparam int D = 4;
  localparam int P = 2;

  logic clk = 1'b0;
  logic rst, set_btn, clr_btn;
  logic s_out, r_out, busy, conf;
  int   checks = 0;
  int   errors = 0;

  sr_cmd_gen #(.DEBOUNCE_CYCLES(D), .PULSE_CYCLES(P)) dut (
    .clk_i(clk), .rst_i(rst), .set_btn_i(set_btn), .clr_btn_i(clr_btn),
    .S_o(s_out), .R_o(r_out), .busy_o(busy), .conflict_o(conf)
  );

  always #5 clk = ~clk;

  // Reference model: a level is accepted once the last D synchronized samples (raw samples
  // two edges old) all disagree with the accepted level; served requests occupy P+1 cycles.
  logic [D:0] m_hs, m_hc;
  logic       m_ds, m_dc, m_ds_prev, m_dc_prev;
  logic       m_ps, m_pc, m_kind_s;
  int         m_rem;
  logic       m_rise_s, m_rise_c;
  logic       exp_s, exp_r, exp_b, exp_c;

  function automatic logic deb_next(input logic [D:0] h, input logic d);
    logic all_diff;
    all_diff = 1'b1;
    for (int i = 1; i <= D; i++) if (h[i] == d) all_diff = 1'b0;
    return all_diff ? ~d : d;
  endfunction

  assign m_rise_s = m_ds & ~m_ds_prev;
  assign m_rise_c = m_dc & ~m_dc_prev;
  assign exp_s = (m_rem > 1) && m_kind_s;
  assign exp_r = (m_rem > 1) && !m_kind_s;
  assign exp_b = (m_rem != 0);
  assign exp_c = (m_rem == 0) && m_ps && m_pc;

  always @(posedge clk) begin
    if (rst) begin
      m_hs <= '0; m_hc <= '0;
      m_ds <= 1'b0; m_dc <= 1'b0; m_ds_prev <= 1'b0; m_dc_prev <= 1'b0;
      m_ps <= 1'b0; m_pc <= 1'b0; m_kind_s <= 1'b0; m_rem <= 0;
    end else begin
      m_hs <= {m_hs[D-1:0], set_btn};
      m_hc <= {m_hc[D-1:0], clr_btn};
      m_ds <= deb_next(m_hs, m_ds);
      m_dc <= deb_next(m_hc, m_dc);
      m_ds_prev <= m_ds;
      m_dc_prev <= m_dc;
      if (m_rem != 0) begin
        m_rem <= m_rem - 1;
        m_ps  <= m_ps | m_rise_s;
        m_pc  <= m_pc | m_rise_c;
      end else if (m_ps && m_pc) begin
        m_ps <= m_rise_s;
        m_pc <= m_rise_c;
      end else if (m_ps) begin
        m_kind_s <= 1'b1;
        m_rem    <= P + 1;
        m_ps     <= m_rise_s;
        m_pc     <= m_rise_c;
      end else if (m_pc) begin
        m_kind_s <= 1'b0;
        m_rem    <= P + 1;
        m_ps     <= m_rise_s;
        m_pc     <= m_rise_c;
      end else begin
        m_ps <= m_rise_s;
        m_pc <= m_rise_c;
      end
    end
  end

  task automatic test_reset();
    int first_s = -1;
    int pulses = 0;
    logic prev_s = 1'b0;
    rst = 1'b1; set_btn = 1'b1; clr_btn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({s_out, r_out, busy, conf} !== 4'b0000) begin
        errors++; $display("FAIL reset_outs cyc=%0d got %b exp 0000", k, {s_out, r_out, busy, conf});
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      checks++;
      if ({s_out, r_out, busy, conf} !== {exp_s, exp_r, exp_b, exp_c}) begin
        errors++; $display("FAIL reset_model k=%0d got %b exp %b", k, {s_out, r_out, busy, conf}, {exp_s, exp_r, exp_b, exp_c});
      end
      if (s_out && !prev_s) begin
        pulses++;
        if (first_s < 0) first_s = k;
      end
      prev_s = s_out;
    end
    checks++;
    if (first_s != 8) begin errors++; $display("FAIL reset_first_s got %0d exp 8", first_s); end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL reset_pulses got %0d exp 1", pulses); end
    set_btn = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_clean_press();
    int first_s = -1;
    int s_cnt = 0, b_cnt = 0, r_cnt = 0;
    set_btn = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 20) set_btn = 1'b0;
      checks++;
      if ({s_out, r_out, busy, conf} !== {exp_s, exp_r, exp_b, exp_c}) begin
        errors++; $display("FAIL clean_model k=%0d got %b exp %b", k, {s_out, r_out, busy, conf}, {exp_s, exp_r, exp_b, exp_c});
      end
      if (s_out && first_s < 0) first_s = k;
      s_cnt += int'(s_out); b_cnt += int'(busy); r_cnt += int'(r_out);
    end
    checks++;
    if (first_s != 8) begin errors++; $display("FAIL clean_first_s got %0d exp 8", first_s); end
    checks++;
    if (s_cnt != P) begin errors++; $display("FAIL clean_s_width got %0d exp %0d", s_cnt, P); end
    checks++;
    if (b_cnt != P + 1) begin errors++; $display("FAIL clean_busy got %0d exp %0d", b_cnt, P + 1); end
    checks++;
    if (r_cnt != 0) begin errors++; $display("FAIL clean_r got %0d exp 0", r_cnt); end
  endtask

  task automatic test_glitch();
    logic [19:0] pat = 20'b1110_0100_1101_1010_0000;
    int r_cnt = 0, b_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      clr_btn = (k < 20) ? pat[19-k] : 1'b0;
      @(negedge clk);
      checks++;
      if ({s_out, r_out, busy, conf} !== {exp_s, exp_r, exp_b, exp_c}) begin
        errors++; $display("FAIL glitch_model k=%0d got %b exp %b", k, {s_out, r_out, busy, conf}, {exp_s, exp_r, exp_b, exp_c});
      end
      r_cnt += int'(r_out); b_cnt += int'(busy);
    end
    checks++;
    if (r_cnt != 0 || b_cnt != 0) begin
      errors++; $display("FAIL glitch_quiet got r=%0d busy=%0d exp 0 0", r_cnt, b_cnt);
    end
  endtask

  task automatic test_simultaneous();
    int first_c = -1;
    int c_cnt = 0, sr_cnt = 0, b_cnt = 0;
    set_btn = 1'b1; clr_btn = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 20) begin set_btn = 1'b0; clr_btn = 1'b0; end
      checks++;
      if ({s_out, r_out, busy, conf} !== {exp_s, exp_r, exp_b, exp_c}) begin
        errors++; $display("FAIL simul_model k=%0d got %b exp %b", k, {s_out, r_out, busy, conf}, {exp_s, exp_r, exp_b, exp_c});
      end
      if (conf && first_c < 0) first_c = k;
      c_cnt += int'(conf); sr_cnt += int'(s_out) + int'(r_out); b_cnt += int'(busy);
    end
    checks++;
    if (first_c != 7) begin errors++; $display("FAIL simul_conf_edge got %0d exp 7", first_c); end
    checks++;
    if (c_cnt != 1) begin errors++; $display("FAIL simul_conf_cnt got %0d exp 1", c_cnt); end
    checks++;
    if (sr_cnt != 0 || b_cnt != 0) begin
      errors++; $display("FAIL simul_quiet got sr=%0d busy=%0d exp 0 0", sr_cnt, b_cnt);
    end
  endtask

  task automatic test_queued();
    logic es, er;
    set_btn = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 2) clr_btn = 1'b1;
      if (k == 25) begin set_btn = 1'b0; clr_btn = 1'b0; end
      es = (k == 8 || k == 9);
      er = (k == 12 || k == 13);
      checks++;
      if ({s_out, r_out} !== {es, er}) begin
        errors++; $display("FAIL queued_seq k=%0d got SR=%b exp %b", k, {s_out, r_out}, {es, er});
      end
      checks++;
      if ({s_out, r_out, busy, conf} !== {exp_s, exp_r, exp_b, exp_c}) begin
        errors++; $display("FAIL queued_model k=%0d got %b exp %b", k, {s_out, r_out, busy, conf}, {exp_s, exp_r, exp_b, exp_c});
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    int r_cnt = 0;
    set_btn = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) clr_btn = 1'b1;
      if (k == 8) begin
        checks++;
        if (s_out !== 1'b1) begin errors++; $display("FAIL midrst_s_before got %b exp 1", s_out); end
        rst = 1'b1;
      end
      if (k == 9) begin
        checks++;
        if ({s_out, r_out, busy, conf} !== 4'b0000) begin
          errors++; $display("FAIL midrst_outs got %b exp 0000", {s_out, r_out, busy, conf});
        end
        set_btn = 1'b0; clr_btn = 1'b0;
      end
      if (k == 10) rst = 1'b0;
      if (k >= 9) begin
        r_cnt += int'(r_out);
        checks++;
        if ({s_out, r_out, busy, conf} !== {exp_s, exp_r, exp_b, exp_c}) begin
          errors++; $display("FAIL midrst_model k=%0d got %b exp %b", k, {s_out, r_out, busy, conf}, {exp_s, exp_r, exp_b, exp_c});
        end
      end
    end
    checks++;
    if (r_cnt != 0) begin errors++; $display("FAIL midrst_no_r got %0d exp 0", r_cnt); end
  endtask

  task automatic test_random();
    int hold_s = 0, hold_c = 0, rst_len = 0;
    for (int k = 0; k < 4000; k++) begin
      if (hold_s == 0) begin set_btn = $urandom_range(1, 0) == 1; hold_s = $urandom_range(12, 1); end
      if (hold_c == 0) begin clr_btn = $urandom_range(1, 0) == 1; hold_c = $urandom_range(12, 1); end
      hold_s--; hold_c--;
      if (rst_len > 0) rst_len--;
      else if ($urandom_range(599, 0) == 0) rst_len = $urandom_range(3, 1);
      rst = (rst_len > 0);
      @(negedge clk);
      checks++;
      if ({s_out, r_out, busy, conf} !== {exp_s, exp_r, exp_b, exp_c}) begin
        errors++; $display("FAIL random_model k=%0d got %b exp %b", k, {s_out, r_out, busy, conf}, {exp_s, exp_r, exp_b, exp_c});
      end
      checks++;
      if ((s_out & r_out) !== 1'b0) begin errors++; $display("FAIL random_excl k=%0d got S&R=1 exp 0", k); end
    end
    rst = 1'b0; set_btn = 1'b0; clr_btn = 1'b0;
  endtask

  initial begin
    rst = 1'b1; set_btn = 1'b0; clr_btn = 1'b0;
    test_reset();
    test_clean_press();
    test_glitch();
    test_simultaneous();
    test_queued();
    test_reset_mid_pulse();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
